seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexing scan controller that shares one seg7 decoder across `NUM_DIGITS` common-anode digits. Holds a double-buffered hex value, steps a refresh prescaler and digit index, and drives the decoder's `bin_in`/`blank`/`test` inputs together with one-hot active-low digit enables. Handles anti-ghosting gaps, leading-zero blanking, frame-synchronous value updates and lamp test. Sits between the value-producing logic and the board's shared segment bus.

## Interface
- `NUM_DIGITS`, 4, digits scanned; legal range 1..8.
- `DIV`, 50000, clocks per digit slot; must be greater than `GAP`.
- `GAP`, 2, clocks at slot start with all digits off; must be at least 1.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `value_in` in 4*NUM_DIGITS: hex value; nibble i drives digit i, digit 0 least significant.
- `load` in 1: one-cycle strobe; captures `value_in` into the pending register.
- `lzb_en` in 1: leading-zero blanking enable, level.
- `lamp_req` in 1: lamp test request, level.
- `dig_bin` out 4: to decoder `bin_in`.
- `dig_blank` out 1: to decoder `blank`; active-low, 0 turns all segments off.
- `dig_test` out 1: to decoder `test`; active-low, 0 lights all segments.
- `dig_sel` out NUM_DIGITS: digit enables, active-low, at most one bit low.
- `frame_done` out 1: one-cycle pulse at the end of each frame.
- `lamp_active` out 1: high for the whole of a lamp-test frame.

## Operation
- Registers:
  - `cnt`, range 0..DIV-1.
  - `idx`, range 0..NUM_DIGITS-1.
  - `disp`, the committed value.
  - `pend` and `pend_v`.
  - `lamp`.
- FSM states:
  - GAP while `cnt < GAP`.
  - SHOW while `GAP <= cnt <= DIV-1`.
- Slot end: `cnt` equals DIV-1. `cnt` goes to 0, `idx` increments, and the FSM returns to GAP.
- Frame end: slot end with `idx` equal to NUM_DIGITS-1. At frame end:
  - `idx` wraps to 0.
  - `frame_done` pulses.
  - If `pend_v` is set: `disp` takes `pend` and `pend_v` clears.
  - `lamp` takes the value of `lamp_req`.
- `load`:
  - Sets `pend` to `value_in` and sets `pend_v`.
  - With repeated loads before commit, the last one wins.
  - If `load` coincides with frame end, the commit uses `pend` as it was before this cycle. The new value stays pending until the next frame end.
- GAP outputs: `dig_sel` is all ones, `dig_blank` is 0, `dig_test` is 1.
- SHOW outputs:
  - `dig_sel[idx]` is 0.
  - `dig_bin` is `disp[idx]`.
  - `dig_test` is the inverse of `lamp`.
  - `dig_blank` is 0 when LZB applies, otherwise 1.
- LZB rule: applies when all of the following hold:
  - `lzb_en` is high.
  - `lamp` is 0.
  - `idx` is not 0.
  - Every nibble of `disp` from NUM_DIGITS-1 down to `idx` is 0.

  Digit 0 is never LZB-blanked.
- Lamp frame: all digits show all segments, `lamp_active` is 1, and `disp` is unaffected.
- A `lamp_req` change in mid-frame has no effect until the next frame end.

## Timing
- All outputs are registered. Each reflects the `cnt`/`idx`/`disp`/`lamp` state of the previous cycle, which is one cycle of latency.
- Reset values:
  - `cnt`=0, `idx`=0, `disp`=0, `pend_v`=0, `lamp`=0.
  - `dig_sel` all ones, `dig_blank`=0, `dig_test`=1, `dig_bin`=0.
  - `frame_done`=0, `lamp_active`=0.
- The first cycle after reset deassert is slot 0, `cnt`=0. `dig_sel[0]` goes low at cycle GAP+1.
- Frame period is NUM_DIGITS*DIV clocks. `frame_done` is high for the single cycle after the frame-end cycle.
- Committed data appears at `dig_bin` no earlier than slot 0 SHOW of the following frame. A loaded value is never displayed partially within one frame.
- Reset asserted mid-operation:
  - Next edge: all state returns to reset values and any pending load is discarded.
  - Outputs return to reset values one cycle later.
  - No digit is enabled during or in the cycle after reset.
- Two digits are never simultaneously low. Every `idx` change happens while `dig_sel` is all ones.

## Structure
- `seg7_scan_pkg`:
  - State enum `scan_state_t` with values GAP and SHOW.
  - Constant `SEL_OFF` (all-ones enable).
  - Function `lz_mask(disp, n)`, returning the per-digit LZB blank vector.
- Sub-module `seg7_tick_gen(DIV, GAP)`:
  - Owns `cnt`.
  - Outputs `in_gap` and `slot_end`.
  - Shares `clk` and `reset`.
- The seg7 decoder is instantiated by the parent, not inside this block.

## Test plan
- Reset, then run with NUM_DIGITS=4, DIV=8, GAP=2, and `load` of 0x1234 before the first frame end:
  - Frame 1 shows 0000.
  - Frame 2 shows, per slot, `dig_bin` 4,3,2,1 with `dig_sel` 1110,1101,1011,0111.
  - Each enable is low for 6 of 8 cycles.
  - `frame_done` fires every 32 cycles.
- Load 0x00A0 with `lzb_en`=1, after commit:
  - Digits 3 and 2 have `dig_blank`=0.
  - Digit 1 shows A.
  - Digit 0 shows 0 unblanked.
- Load 0x0000 with `lzb_en`=1: only digit 0 is lit, showing 0.
- Pulse `lamp_req` mid-frame:
  - No change until the frame ends.
  - The next frame has `dig_test`=0 and `lamp_active`=1 on all slots, with LZB ignored.
  - The frame after returns to normal once `lamp_req`=0.
- Loads 0x1111 then 0x2222 in one frame, then 0x3333 on the frame-end cycle:
  - The next frame shows 2222.
  - The frame after shows 3333.
- Assert `reset` in slot 2 SHOW:
  - One cycle later, `dig_sel`=1111 and `dig_blank`=0.
  - `disp` is 0.
  - The pending load is dropped, and scanning restarts at slot 0.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_pkg
// Shared types and helpers for the seven-segment scan controller.
//   scan_state_t : per-slot phase, GAP (all digits dark) or SHOW (one digit lit)
//   SEL_OFF      : all-ones active-low digit enable vector (no digit selected)
//   lz_mask()    : per-digit leading-zero blank vector for a packed hex value
// -----------------------------------------------------------------------------
package seg7_scan_pkg;

    localparam int MAX_DIGITS = 8;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    localparam logic [MAX_DIGITS-1:0] SEL_OFF = '1;

    // Bit i is set when digit i and every more significant digit (up to n-1)
    // hold zero. Digit 0 is never flagged so a zero value still shows "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] d,
                                                      input int n);
        logic [MAX_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                zero_above = zero_above & (d[4*i +: 4] == 4'h0);
                m[i]       = zero_above;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// -----------------------------------------------------------------------------
// seg7_tick_gen
// Refresh prescaler for one digit slot. Counts 0..DIV-1 and wraps.
//   clk      in  : clock
//   reset    in  : synchronous active-high reset, forces the count to 0
//   in_gap   out : count is in the dark gap at the start of the slot (cnt < GAP)
//   slot_end out : count is at its last value (cnt == DIV-1)
// -----------------------------------------------------------------------------
module seg7_tick_gen #(
    parameter int DIV = 50000,
    parameter int GAP = 2
) (
    input  logic clk,
    input  logic reset,
    output logic in_gap,
    output logic slot_end
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_reg;

    assign slot_end = (cnt_reg == CW'(DIV - 1));
    assign in_gap   = (cnt_reg < CW'(GAP));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (slot_end) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing
// one external seg7 decoder. Double-buffered value, frame-synchronous commit,
// anti-ghosting gap, leading-zero blanking and lamp test.
//   clk         in  : clock
//   reset       in  : synchronous active-high reset
//   value_in    in  : hex value, nibble i -> digit i
//   load        in  : strobe, captures value_in into the pending buffer
//   lzb_en      in  : leading-zero blanking enable (level)
//   lamp_req    in  : lamp test request (level, sampled at frame end)
//   dig_bin     out : decoder bin_in
//   dig_blank   out : decoder blank, active-low
//   dig_test    out : decoder test, active-low
//   dig_sel     out : one-hot active-low digit enables
//   frame_done  out : one-cycle pulse after each frame end
//   lamp_active out : high throughout a lamp-test frame
// All outputs are registered from the previous cycle's scan state.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int GAP        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    lzb_en,
    input  logic                    lamp_req,
    output logic [3:0]              dig_bin,
    output logic                    dig_blank,
    output logic                    dig_test,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done,
    output logic                    lamp_active
);

    localparam int              IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic in_gap;
    logic slot_end;

    seg7_tick_gen #(
        .DIV (DIV),
        .GAP (GAP)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .in_gap   (in_gap),
        .slot_end (slot_end)
    );

    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic                    pend_v_reg;
    logic                    lamp_reg;

    scan_state_t             state;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   sel_show;

    assign state     = in_gap ? seg7_scan_pkg::GAP : SHOW;
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    // Blanking never applies during a lamp frame so every segment can be seen.
    assign lz_blank = NUM_DIGITS'(lz_mask((4*MAX_DIGITS)'(disp_reg), NUM_DIGITS))
                    & {NUM_DIGITS{lzb_en & ~lamp_reg}};

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign sel_show[gi] = (idx_reg != IDX_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg     <= '0;
            disp_reg    <= '0;
            pend_reg    <= '0;
            pend_v_reg  <= 1'b0;
            lamp_reg    <= 1'b0;
            dig_sel     <= SEL_OFF[NUM_DIGITS-1:0];
            dig_blank   <= 1'b0;
            dig_test    <= 1'b1;
            dig_bin     <= 4'h0;
            frame_done  <= 1'b0;
            lamp_active <= 1'b0;
        end else begin
            // idx only moves at slot end, which is always followed by a gap,
            // so the enable vector is all ones whenever the digit changes.
            if (slot_end) begin
                idx_reg <= frame_end ? '0 : idx_reg + 1'b1;
            end

            // Commit uses the pending buffer as it stood before this cycle; a
            // load landing on the same edge stays pending for the next frame.
            if (frame_end) begin
                if (pend_v_reg) begin
                    disp_reg <= pend_reg;
                end
                pend_v_reg <= 1'b0;
                lamp_reg   <= lamp_req;
            end
            if (load) begin
                pend_reg   <= value_in;
                pend_v_reg <= 1'b1;
            end

            dig_bin     <= disp_reg[4*idx_reg +: 4];
            frame_done  <= frame_end;
            lamp_active <= lamp_reg;

            case (state)
                seg7_scan_pkg::GAP: begin
                    dig_sel   <= SEL_OFF[NUM_DIGITS-1:0];
                    dig_blank <= 1'b0;
                    dig_test  <= 1'b1;
                end
                default: begin
                    dig_sel   <= sel_show;
                    dig_blank <= ~lz_blank[idx_reg];
                    dig_test  <= ~lamp_reg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Directed scenarios followed by random loads / lzb / lamp traffic, checked
// every cycle against a time-indexed reference model: slot and position are
// derived arithmetically from the cycle number since reset, and the displayed
// value, pending buffer and lamp flag are updated at frame boundaries.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = N * DIV;

    logic           clk      = 1'b0;
    logic           reset    = 1'b1;
    logic [4*N-1:0] value_in = '0;
    logic           load     = 1'b0;
    logic           lzb_en   = 1'b0;
    logic           lamp_req = 1'b0;
    logic [3:0]     dig_bin;
    logic           dig_blank;
    logic           dig_test;
    logic [N-1:0]   dig_sel;
    logic           frame_done;
    logic           lamp_active;

    seg7_scan_ctrl #(
        .NUM_DIGITS (N),
        .DIV        (DIV),
        .GAP        (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .load        (load),
        .lzb_en      (lzb_en),
        .lamp_req    (lamp_req),
        .dig_bin     (dig_bin),
        .dig_blank   (dig_blank),
        .dig_test    (dig_test),
        .dig_sel     (dig_sel),
        .frame_done  (frame_done),
        .lamp_active (lamp_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int t        = 0;   // cycles since the last reset edge

    // reference model state
    logic [15:0] m_disp   = '0;
    logic [15:0] m_pend   = '0;
    bit          m_pend_v = 1'b0;
    bit          m_lamp   = 1'b0;

    // expected registered outputs for the coming cycle
    logic [N-1:0] e_sel;
    logic [3:0]   e_bin;
    bit           e_bin_valid;
    bit           e_blank;
    bit           e_test;
    bit           e_fd;
    bit           e_la;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
        end
    endtask

    task automatic expect_reset();
        e_sel       = '1;
        e_bin       = 4'h0;
        e_bin_valid = 1'b1;
        e_blank     = 1'b0;
        e_test      = 1'b1;
        e_fd        = 1'b0;
        e_la        = 1'b0;
    endtask

    // Outputs produced from the scan state during cycle t.
    task automatic predict();
        int pos;
        int slot;
        pos   = t % DIV;
        slot  = (t / DIV) % N;
        e_fd  = ((t % FRAME) == FRAME - 1);
        e_la  = m_lamp;
        e_bin = 4'(m_disp >> (4 * slot));
        if (pos < GAP) begin
            e_bin_valid = 1'b0;
            e_sel       = '1;
            e_blank     = 1'b0;
            e_test      = 1'b1;
        end else begin
            e_bin_valid = 1'b1;
            e_sel       = ~(N'(1) << slot);
            e_test      = !m_lamp;
            e_blank     = !(lzb_en && !m_lamp && slot != 0 && (m_disp >> (4 * slot)) == 16'h0);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        $display("load t=%0d value=%h", t, v);
    endtask

    initial begin
        int  fr;
        int  p;
        int  step;
        bit  phase1;
        bit  done;
        bit  do_rst;

        phase1 = 1'b0;
        done   = 1'b0;
        step   = 0;
        expect_reset();
        repeat (3) @(negedge clk);

        while (!done && step < 5000) begin
            step++;
            check("dig_sel",     32'(dig_sel),     32'(e_sel));
            check("dig_blank",   32'(dig_blank),   32'(e_blank));
            check("dig_test",    32'(dig_test),    32'(e_test));
            check("frame_done",  32'(frame_done),  32'(e_fd));
            check("lamp_active", 32'(lamp_active), 32'(e_la));
            check("one_enable",  32'($countones(~dig_sel) <= 1), 32'(1));
            if (e_bin_valid) check("dig_bin", 32'(dig_bin), 32'(e_bin));

            fr       = t / FRAME;
            p        = t % FRAME;
            reset    = 1'b0;
            load     = 1'b0;
            value_in = 16'($urandom);
            do_rst   = 1'b0;

            if (phase1) begin
                lzb_en   = 1'b0;
                lamp_req = 1'b0;
                if (t >= 2 * FRAME) done = 1'b1;
            end else begin
                lzb_en   = (fr >= 2 && fr <= 8);
                lamp_req = (fr == 6 && p >= 14) || (fr == 7 && p < 10);
                if (fr == 0 && p == 5)  do_load(16'h1234);
                if (fr == 2 && p == 10) do_load(16'h00A0);
                if (fr == 4 && p == 20) do_load(16'h0000);
                if (fr == 8 && p == 3)  do_load(16'h1111);
                if (fr == 8 && p == 17) do_load(16'h2222);
                if (fr == 8 && p == FRAME - 1) do_load(16'h3333);
                if (fr >= 10 && fr < 18) begin
                    lzb_en   = ($urandom_range(0, 3) != 0);
                    lamp_req = ($urandom_range(0, 4) == 0);
                    if ($urandom_range(0, 11) == 0)
                        do_load(16'($urandom) >> (4 * $urandom_range(0, 4)));
                end
                if (fr == 18 && p == DIV + 3) do_load(16'hBEEF);
                if (fr == 18 && p == 2 * DIV + 4) begin
                    do_rst = 1'b1;
                    reset  = 1'b1;
                    phase1 = 1'b1;
                    $display("reset t=%0d (slot 2 show)", t);
                end
            end

            if (do_rst) begin
                expect_reset();
                m_disp   = '0;
                m_pend   = '0;
                m_pend_v = 1'b0;
                m_lamp   = 1'b0;
                t        = 0;
            end else begin
                predict();
                if (p == FRAME - 1) begin
                    if (m_pend_v) begin
                        m_disp   = m_pend;
                        m_pend_v = 1'b0;
                    end
                    m_lamp = lamp_req;
                    $display("frame %0d end: next disp=%h lamp=%0d", fr, m_disp, m_lamp);
                end
                if (load) begin
                    m_pend   = value_in;
                    m_pend_v = 1'b1;
                end
                t++;
            end

            if (!done) @(negedge clk);
        end

        check("run_completed", 32'(done), 32'(1));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
